ant_freq_meter: RTL and testbench

Measures the frequency of the conditioned antenna return signal that comes back from the theremin antenna LC network. The antenna is driven by the square-wave oscillator stage. The block counts rising edges of the asynchronous ant_in over a fixed gate window of clk_100 cycles and averages 2^AVG_LOG2 gates. It publishes the result with a one-cycle valid strobe to the downstream pitch-mapping logic.

---
 rtl/ant_freq_meter.sv | 151 +++++++++++++++
 tb/tb_ant_freq_meter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_freq_meter.sv
// Antenna return frequency meter: counts synchronized rising edges of ant_in over
// fixed clk_100 gate windows and publishes the floor-average of 2^AVG_LOG2 gates.
module ant_freq_meter #(
  parameter logic [31:0] GATE_CYCLES = 32'd1_000_000,
  parameter int          CNT_W       = 16,
  parameter int          AVG_LOG2    = 2
) (
  input  logic             clk_100,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ant_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             no_signal,
  output logic             overflow
);

  localparam int TMR_W = $clog2(GATE_CYCLES);
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0] r_gate_idx;
  logic             r_sat_flag;
  logic [CNT_W-1:0] r_freq_count;
  logic             r_count_valid;
  logic             r_no_signal;
  logic             r_overflow;

  logic             w_rise;
  logic             w_cnt_at_max;
  logic             w_terminal;
  logic             w_last_gate;
  logic             w_gate_sat;
  logic [CNT_W-1:0] w_gate_total;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_avg;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_publish;

  assign w_rise       = r_s2 & ~r_s3;
  assign w_cnt_at_max = (r_edge_cnt == CNT_MAX);
  assign w_terminal   = (r_timer == TMR_LAST);
  assign w_last_gate  = (r_gate_idx == IDX_LAST);

  // The rise on the terminal cycle still belongs to the closing gate.
  assign w_gate_sat   = w_rise & w_cnt_at_max;
  assign w_gate_total = (w_rise && !w_cnt_at_max) ? r_edge_cnt + 1'b1 : r_edge_cnt;
  assign w_sum        = r_acc + ACC_W'(w_gate_total);
  assign w_avg        = CNT_W'(w_sum >> AVG_LOG2);
  assign w_idx_next   = w_last_gate ? '0 : r_gate_idx + 1'b1;
  assign w_publish    = (r_state == MEASURE) && w_terminal && w_last_gate;

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_timer       <= '0;
      r_edge_cnt    <= '0;
      r_acc         <= '0;
      r_gate_idx    <= '0;
      r_sat_flag    <= 1'b0;
      r_freq_count  <= '0;
      r_count_valid <= 1'b0;
      r_no_signal   <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_s1          <= ant_in;
      r_s2          <= r_s1;
      r_s3          <= r_s2;
      r_count_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_timer    <= '0;
          r_edge_cnt <= '0;
          r_acc      <= '0;
          r_gate_idx <= '0;
          r_sat_flag <= 1'b0;
          if (enable) begin
            r_state <= MEASURE;
          end
        end

        MEASURE: begin
          // A publish on the final terminal cycle survives enable falling on that cycle.
          if (w_publish) begin
            r_freq_count  <= w_avg;
            r_no_signal   <= (w_sum == '0);
            r_overflow    <= r_sat_flag | w_gate_sat;
            r_count_valid <= 1'b1;
          end

          if (!enable) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_acc      <= '0;
            r_gate_idx <= '0;
            r_sat_flag <= 1'b0;
          end else if (w_terminal) begin
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_gate_idx <= w_idx_next;
            if (w_last_gate) begin
              r_acc      <= '0;
              r_sat_flag <= 1'b0;
            end else begin
              r_acc      <= w_sum;
              r_sat_flag <= r_sat_flag | w_gate_sat;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
            if (w_rise) begin
              if (w_cnt_at_max) begin
                r_sat_flag <= 1'b1;
              end else begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
              end
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign freq_count  = r_freq_count;
  assign count_valid = r_count_valid;
  assign no_signal   = r_no_signal;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ant_freq_meter.sv
// Bench for ant_freq_meter: two builds (CNT_W=8 and CNT_W=5) share one stimulus stream
// and are checked every cycle against a gate-window edge-counting reference model.
module tb_ant_freq_meter;

  localparam int G    = 100;
  localparam int NAVG = 4;
  localparam int HMAX = 40000;

  logic       clk_100 = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       ant_in  = 1'b0;
  logic [7:0] fc8;
  logic       cv8, ns8, ov8;
  logic [4:0] fc5;
  logic       cv5, ns5, ov5;

  always #5 clk_100 = ~clk_100;

  ant_freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(8), .AVG_LOG2(2)) u_dut8 (
    .clk_100(clk_100), .reset_n(reset_n), .enable(enable), .ant_in(ant_in),
    .freq_count(fc8), .count_valid(cv8), .no_signal(ns8), .overflow(ov8)
  );

  ant_freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(5), .AVG_LOG2(2)) u_dut5 (
    .clk_100(clk_100), .reset_n(reset_n), .enable(enable), .ant_in(ant_in),
    .freq_count(fc5), .count_valid(cv5), .no_signal(ns5), .overflow(ov5)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit hist [0:HMAX-1];

  // Reference model state: is a batch running, and at which clock edge it started.
  bit m_active = 1'b0;
  int m_s      = 0;
  int e_fc [2] = '{0, 0};
  bit e_cv [2] = '{0, 0};
  bit e_ns [2] = '{0, 0};
  bit e_ov [2] = '{0, 0};

  // Stimulus generator: period 0 holds ant_in at lvl.
  int ph     = 0;
  int period = 10;
  bit lvl    = 1'b0;

  // Rising edges seen by the counter at clock edges a+1..b (three-edge input latency).
  function automatic int gate_edges(int a, int b);
    int n = 0;
    for (int k = a + 1; k <= b; k++) begin
      if (hist[k-2] && !hist[k-3]) n++;
    end
    return n;
  endfunction

  task automatic model_step(bit en, bit rs);
    int sum [2];
    bit sat [2];
    int mx  [2];
    int n;
    e_cv[0] = 1'b0;
    e_cv[1] = 1'b0;
    if (rs) begin
      m_active = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_fc[i] = 0; e_ns[i] = 1'b0; e_ov[i] = 1'b0;
      end
      return;
    end
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_s      = cyc;
      end
    end else begin
      if (cyc - m_s == G * NAVG) begin
        mx[0] = 255; mx[1] = 31;
        for (int i = 0; i < 2; i++) begin
          sum[i] = 0; sat[i] = 1'b0;
        end
        for (int j = 0; j < NAVG; j++) begin
          n = gate_edges(m_s + j * G, m_s + (j + 1) * G);
          for (int i = 0; i < 2; i++) begin
            if (n > mx[i]) begin
              sat[i] = 1'b1;
              sum[i] += mx[i];
            end else begin
              sum[i] += n;
            end
          end
        end
        for (int i = 0; i < 2; i++) begin
          e_fc[i] = sum[i] / NAVG;
          e_ns[i] = (sum[i] == 0);
          e_ov[i] = sat[i];
          e_cv[i] = 1'b1;
        end
        m_s = cyc;
      end
      if (!en) m_active = 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("freq_count8",  32'(fc8), 32'(e_fc[0]));
    chk("count_valid8", 32'(cv8), 32'(e_cv[0]));
    chk("no_signal8",   32'(ns8), 32'(e_ns[0]));
    chk("overflow8",    32'(ov8), 32'(e_ov[0]));
    chk("freq_count5",  32'(fc5), 32'(e_fc[1]));
    chk("count_valid5", 32'(cv5), 32'(e_cv[1]));
    chk("no_signal5",   32'(ns5), 32'(e_ns[1]));
    chk("overflow5",    32'(ov5), 32'(e_ov[1]));
  endtask

  // Called just after a falling edge: log the inputs the next rising edge will sample,
  // let that edge pass, check outputs at the following falling edge, then drive ant_in.
  task automatic tick();
    bit en_s, rs_s;
    cyc++;
    hist[cyc] = reset_n ? ant_in : 1'b0;
    en_s      = enable;
    rs_s      = !reset_n;
    @(negedge clk_100);
    model_step(en_s, rs_s);
    check_all();
    if (period == 0) begin
      ant_in = lvl;
    end else begin
      ant_in = (ph % period) < (period / 2);
      ph++;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!cv8 && k < 600) begin
      tick();
      k++;
    end
    chk("wait_count_valid", 32'(cv8), 32'd1);
  endtask

  initial begin
    @(negedge clk_100);
    reset_n = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(2);

    // Nominal: period 10 gives 10 edges per gate.
    period = 10; ph = $urandom_range(0, 9);
    enable = 1'b1;
    run(1300);

    // Averaging floor: mix of 10 and ~11 edges per gate.
    run(200);
    period = 9;
    run(200);
    run(800);

    // No signal, low then high, then recovery.
    period = 0; lvl = 1'b0;
    run(900);
    lvl = 1'b1;
    run(900);
    period = 10; ph = $urandom_range(0, 9);
    run(900);

    // Saturation: 50 edges per gate overflows the 5-bit build only.
    period = 2;
    run(900);
    period = 10;
    run(900);

    // Enable drop 250 cycles into a batch.
    wait_valid();
    run(249);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    run(900);

    // Enable falling exactly on a publishing terminal cycle.
    begin
      int k = 0;
      while (!(m_active && (cyc == m_s + G * NAVG - 1)) && k < 600) begin
        tick();
        k++;
      end
      chk("align_terminal", 32'(cyc == m_s + G * NAVG - 1), 32'd1);
    end
    enable = 1'b0;
    tick();
    run(10);
    enable = 1'b1;
    run(900);

    // Asynchronous reset mid-batch.
    wait_valid();
    run(329);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_fc8", 32'(fc8), 32'd0);
    chk("async_rst_ns8", 32'(ns8), 32'd0);
    chk("async_rst_ov8", 32'(ov8), 32'd0);
    chk("async_rst_cv8", 32'(cv8), 32'd0);
    chk("async_rst_fc5", 32'(fc5), 32'd0);
    chk("async_rst_ov5", 32'(ov5), 32'd0);
    run(3);
    reset_n = 1'b1;
    run(900);

    // Randomized segments with occasional enable glitches.
    repeat (6) begin
      period = $urandom_range(2, 40);
      ph     = $urandom_range(0, 1000);
      run($urandom_range(300, 900));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 30));
        enable = 1'b1;
      end
    end
    run(450);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
